// File: rtl/aoc_pkg.sv
// Shared parser definitions: FSM state type, ASCII character codes, character-class helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aoc_pkg;

    typedef logic [1:0] parseState_t;

    localparam parseState_t PARSE_IDLE   = 2'd0;
    localparam parseState_t PARSE_DIGITS = 2'd1;
    localparam parseState_t PARSE_EMIT   = 2'd2;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_SP = 8'h20;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/rotation_parser_if.sv
// Byte-in / rotation-out bundle for the rotation parser (slave = parser, master = driver/consumer).
// Latency: n/a (wiring only).
// Backpressure: inValid/inReady on the byte side, rotValid/rotReady on the record side.
interface rotation_parser_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
);
    logic [7:0]           inByte;
    logic                 inValid;
    logic                 inReady;
    logic                 rotDir;
    logic [WIDTH-1:0]     rotMag;
    logic                 rotValid;
    logic                 rotReady;
    logic [CNT_WIDTH-1:0] recCount;
`ifdef ROT_PARSE_ERR_EN
    logic                 parseErr;
`endif

    modport master (
        output inByte, inValid, rotReady,
        input  inReady, rotDir, rotMag, rotValid, recCount
`ifdef ROT_PARSE_ERR_EN
        , input parseErr
`endif
    );

    modport slave (
        input  inByte, inValid, rotReady,
        output inReady, rotDir, rotMag, rotValid, recCount
`ifdef ROT_PARSE_ERR_EN
        , output parseErr
`endif
    );
endinterface

// File: rtl/dec_accum.sv
// Decimal accumulator: clear, acc = acc*10 + digit, saturating at all-ones; tracks "any digit seen".
// Latency: one cycle from clr/dig_vld to updated acc/has_digit.
// Backpressure: none; caller qualifies dig_vld with its own handshake.
module dec_accum #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             dig_vld,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] acc,
    output logic             has_digit
);
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH+3:0] acc_next;

    // acc*10 as two shifts in WIDTH+4 bits, which cannot wrap even at acc = all-ones plus digit 9
    always_comb begin
        acc_ext  = {4'b0000, acc};
        acc_next = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};
    end

    // Once saturated, every further digit also overflows, so the value holds at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            has_digit <= 1'b0;
        end else if (clr) begin
            acc       <= '0;
            has_digit <= 1'b0;
        end else if (dig_vld) begin
            has_digit <= 1'b1;
            if (|acc_next[WIDTH+3:WIDTH])
                acc <= '1;
            else
                acc <= acc_next[WIDTH-1:0];
        end
    end
endmodule

// File: rtl/rotation_parser.sv
// Parses ASCII "L<digits>\n" / "R<digits>\n" records into (rotDir, rotMag); ROT_PARSE_ERR_EN adds sticky parseErr.
// Latency: rotValid rises the cycle after the terminating LF is accepted; recCount bumps on record transfer.
// Backpressure: inReady is low while a record is held for rotReady; rotDir/rotMag stay stable until transfer.
module rotation_parser
    import aoc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    rotation_parser_if.slave bus
);
    parseState_t          state;
    parseState_t          state_nxt;
    logic                 in_rdy;
    logic                 byte_acc;
    logic                 rec_xfer;
    logic                 is_dig;
    logic                 is_lr;
    logic                 acc_clr;
    logic                 dig_vld;
    logic                 dir_ld;
    logic                 dir_q;
    logic                 has_digit;
    logic [WIDTH-1:0]     acc;
    logic [CNT_WIDTH-1:0] rec_count;
`ifdef ROT_PARSE_ERR_EN
    logic                 err_set;
    logic                 parse_err;
`endif

    assign in_rdy   = (state != PARSE_EMIT);
    assign byte_acc = bus.inValid && in_rdy;
    assign rec_xfer = (state == PARSE_EMIT) && bus.rotReady;
    assign is_dig   = is_digit(bus.inByte);
    assign is_lr    = (bus.inByte == ASCII_L) || (bus.inByte == ASCII_R);

    // Next-state and datapath controls from the current state and the accepted byte
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        dig_vld   = 1'b0;
        dir_ld    = 1'b0;
`ifdef ROT_PARSE_ERR_EN
        err_set   = 1'b0;
`endif
        case (state)
            PARSE_IDLE: begin
                if (byte_acc) begin
                    if (is_lr) begin
                        dir_ld    = 1'b1;
                        acc_clr   = 1'b1;
                        state_nxt = PARSE_DIGITS;
                    end
`ifdef ROT_PARSE_ERR_EN
                    else if ((bus.inByte != ASCII_LF) && (bus.inByte != ASCII_CR) &&
                             (bus.inByte != ASCII_SP)) begin
                        err_set = 1'b1;
                    end
`endif
                end
            end
            PARSE_DIGITS: begin
                if (byte_acc) begin
                    if (is_dig) begin
                        dig_vld = 1'b1;
                    end else if (bus.inByte == ASCII_LF) begin
                        // A bare direction letter with no digits is dropped silently
                        state_nxt = has_digit ? PARSE_EMIT : PARSE_IDLE;
                    end
`ifdef ROT_PARSE_ERR_EN
                    else if (bus.inByte != ASCII_CR) begin
                        err_set   = 1'b1;
                        state_nxt = PARSE_IDLE;
                    end
`endif
                end
            end
            PARSE_EMIT: begin
                if (rec_xfer)
                    state_nxt = PARSE_IDLE;
            end
            default: state_nxt = PARSE_IDLE;
        endcase
    end

    // FSM state register; reset wins over any same-cycle transfer
    always_ff @(posedge clock) begin
        if (reset)
            state <= PARSE_IDLE;
        else
            state <= state_nxt;
    end

    // Direction latched on the record's leading letter, held through EMIT
    always_ff @(posedge clock) begin
        if (reset)
            dir_q <= 1'b0;
        else if (dir_ld)
            dir_q <= (bus.inByte == ASCII_R);
    end

    // Saturating count of records handed downstream
    always_ff @(posedge clock) begin
        if (reset)
            rec_count <= '0;
        else if (rec_xfer && (rec_count != {CNT_WIDTH{1'b1}}))
            rec_count <= rec_count + 1'b1;
    end

`ifdef ROT_PARSE_ERR_EN
    // Sticky malformed-input flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (reset)
            parse_err <= 1'b0;
        else if (err_set)
            parse_err <= 1'b1;
    end

    assign bus.parseErr = parse_err;
`endif

    dec_accum #(.WIDTH(WIDTH)) u_dec_accum (
        .clock     (clock),
        .reset     (reset),
        .clr       (acc_clr),
        .dig_vld   (dig_vld),
        .digit     (bus.inByte[3:0]),
        .acc       (acc),
        .has_digit (has_digit)
    );

    // rotMag is the accumulator register itself so the modulo stage sees it with no extra pipeline
    assign bus.inReady  = in_rdy;
    assign bus.rotValid = (state == PARSE_EMIT);
    assign bus.rotDir   = dir_q;
    assign bus.rotMag   = acc;
    assign bus.recCount = rec_count;
endmodule

// File: tb/tb_rotation_parser.sv
// Self-checking bench for rotation_parser: record-level model plus directed streams with literal expectations.
// Latency: n/a.
// Backpressure: exercised by holding rotReady low while a record is pending.
module tb_rotation_parser;
    localparam int    W       = 16;
    localparam int    CW      = 4;
    localparam longint MAG_MAX = 65535;
    localparam int    CNT_MAX = 15;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rotation_parser_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus();

    rotation_parser #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- record-level model ----------------
    bit     m_in_rec, m_has, m_dir, m_emit, m_dir_exp, m_err;
    longint m_val, m_mag_exp;
    int     m_cnt;

    always @(posedge clock) begin
        logic [7:0] c;
        c = bus.inByte;
        if (reset) begin
            m_in_rec = 0; m_has = 0; m_dir = 0; m_emit = 0;
            m_dir_exp = 0; m_mag_exp = 0; m_val = 0; m_cnt = 0; m_err = 0;
        end else if (m_emit) begin
            if (bus.rotReady) begin
                m_emit = 0;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end else if (bus.inValid) begin
            if (!m_in_rec) begin
                if (c == "L" || c == "R") begin
                    m_in_rec = 1; m_dir = (c == "R"); m_val = 0; m_has = 0;
                end else if (c != 8'h0A && c != 8'h0D && c != 8'h20) begin
`ifdef ROT_PARSE_ERR_EN
                    m_err = 1;
`endif
                end
            end else begin
                if (c >= 8'h30 && c <= 8'h39) begin
                    m_val = m_val * 10 + longint'(c - 8'h30);
                    if (m_val > MAG_MAX) m_val = MAG_MAX;
                    m_has = 1;
                end else if (c == 8'h0A) begin
                    m_in_rec = 0;
                    if (m_has) begin
                        m_emit = 1; m_dir_exp = m_dir; m_mag_exp = m_val;
                    end
                end else if (c != 8'h0D) begin
`ifdef ROT_PARSE_ERR_EN
                    m_err = 1; m_in_rec = 0;
`endif
                end
            end
        end
    end

    // ---------------- per-cycle compare + transfer log ----------------
    bit log_dir[$];
    int log_mag[$];

    always @(negedge clock) begin
        if (chk_en) begin
            chk("rot_valid", bus.rotValid, m_emit);
            chk("in_ready", bus.inReady, !m_emit);
            chk("rec_count", bus.recCount, m_cnt);
            if (m_emit) begin
                chk("rot_dir", bus.rotDir, m_dir_exp);
                chk("rot_mag", bus.rotMag, m_mag_exp);
            end
`ifdef ROT_PARSE_ERR_EN
            chk("parse_err", bus.parseErr, m_err);
`endif
            if (bus.rotValid && bus.rotReady && !reset) begin
                log_dir.push_back(bus.rotDir);
                log_mag.push_back(int'(bus.rotMag));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset = 1'b1;
        bus.inValid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        log_dir.delete();
        log_mag.delete();
    endtask

    task automatic send_byte(input logic [7:0] c);
        bit done = 0;
        int n = 0;
        bus.inByte  = c;
        bus.inValid = 1'b1;
        while (!done) begin
            @(negedge clock);
            if (bus.inReady) done = 1;
            else if (++n > 64) begin
                chk("accept_timeout", bus.inReady, 1);
                done = 1;
            end
        end
        @(posedge clock);
        #1;
        bus.inValid = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            if (gap) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic expect_rec(input string name, input int idx, input bit d, input int m);
        chk({name, "_present"}, longint'(log_mag.size() > idx), 1);
        if (log_mag.size() > idx) begin
            chk({name, "_dir"}, log_dir[idx], d);
            chk({name, "_mag"}, log_mag[idx], m);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inByte   = 8'h00;
        bus.inValid  = 1'b0;
        bus.rotReady = 1'b1;
        do_reset();
        chk_en = 1;

        // Reset state
        @(negedge clock);
        chk("rst_valid", bus.rotValid, 0);
        chk("rst_ready", bus.inReady, 1);
        chk("rst_dir", bus.rotDir, 0);
        chk("rst_mag", bus.rotMag, 0);
        chk("rst_cnt", bus.recCount, 0);
`ifdef ROT_PARSE_ERR_EN
        chk("rst_err", bus.parseErr, 0);
`endif
        @(posedge clock); #1;

        // "L68\n": record valid the cycle after LF, then transferred
        send_str("L68\n", 0);
        @(negedge clock);
        chk("t1_lat_valid", bus.rotValid, 1);
        chk("t1_lat_mag", bus.rotMag, 68);
        drain();
        chk("t1_n", log_mag.size(), 1);
        expect_rec("t1_r0", 0, 0, 68);
        chk("t1_cnt", bus.recCount, 1);

        // "R5\nL30\n" with a 4-cycle downstream stall on the first record
        do_reset();
        bus.rotReady = 1'b0;
        send_str("R5\n", 0);
        repeat (4) begin
            @(negedge clock);
            chk("t2_stall_valid", bus.rotValid, 1);
            chk("t2_stall_ready", bus.inReady, 0);
            chk("t2_stall_dir", bus.rotDir, 1);
            chk("t2_stall_mag", bus.rotMag, 5);
        end
        @(posedge clock); #1;
        bus.rotReady = 1'b1;
        send_str("L30\n", 0);
        drain();
        chk("t2_n", log_mag.size(), 2);
        expect_rec("t2_r0", 0, 1, 5);
        expect_rec("t2_r1", 1, 0, 30);
        chk("t2_cnt", bus.recCount, 2);

        // Saturation
        do_reset();
        send_str("R99999\n", 0);
        drain();
        chk("t3_n", log_mag.size(), 1);
        expect_rec("t3_r0", 0, 1, 65535);

        // Whitespace in idle, dropped empty record, idle gaps on inValid
        do_reset();
        send_str("\n \015L\nR7\n", 1);
        drain();
        chk("t4_n", log_mag.size(), 1);
        expect_rec("t4_r0", 0, 1, 7);
        chk("t4_cnt", bus.recCount, 1);

        // Unexpected character inside a record
        do_reset();
        send_str("L1x2\nR3\n", 0);
        drain();
`ifdef ROT_PARSE_ERR_EN
        chk("t5_n", log_mag.size(), 1);
        expect_rec("t5_r0", 0, 1, 3);
        chk("t5_err", bus.parseErr, 1);
`else
        chk("t5_n", log_mag.size(), 2);
        expect_rec("t5_r0", 0, 0, 12);
        expect_rec("t5_r1", 1, 1, 3);
`endif

        // Reset mid-record discards it
        do_reset();
        send_str("R4", 0);
        do_reset();
        @(negedge clock);
        chk("t6_rst_dir", bus.rotDir, 0);
        chk("t6_rst_mag", bus.rotMag, 0);
        chk("t6_rst_cnt", bus.recCount, 0);
        chk("t6_rst_valid", bus.rotValid, 0);
        @(posedge clock); #1;
        send_str("L2\n", 0);
        drain();
        chk("t6_n", log_mag.size(), 1);
        expect_rec("t6_r0", 0, 0, 2);
        chk("t6_cnt", bus.recCount, 1);

        // Reset while a record is pending discards it without a count
        do_reset();
        bus.rotReady = 1'b0;
        send_str("L9\n", 0);
        do_reset();
        bus.rotReady = 1'b1;
        @(negedge clock);
        chk("t7_cnt", bus.recCount, 0);
        chk("t7_valid", bus.rotValid, 0);
        drain();
        chk("t7_n", log_mag.size(), 0);

        // Record counter saturation (CNT_WIDTH = 4)
        do_reset();
        for (int i = 0; i < 18; i++)
            send_str($sformatf("L%0d\n", i % 10), 0);
        drain();
        chk("t8_n", log_mag.size(), 18);
        chk("t8_cnt_sat", bus.recCount, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rotation_parser.md
ROTATION_PARSER -- requirements
Module: rotation_parser

Interface
REQ-001 Parameter WIDTH, default 16, magnitude width of the emitted rotation.
REQ-002 Parameter CNT_WIDTH, default 16, width of the record counter.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 inByte  input  8  ASCII input character.
REQ-006 inValid  input  1  inByte valid.
REQ-007 inReady  output  1  parser accepts inByte; a byte transfers when inValid && inReady.
REQ-008 rotDir  output  1  0 = L, 1 = R.
REQ-009 rotMag  output  WIDTH  decimal magnitude of the rotation.
REQ-010 rotValid  output  1  rotDir/rotMag valid.
REQ-011 rotReady  input  1  downstream consumer accepts; a record transfers when rotValid && rotReady.
REQ-012 recCount  output  CNT_WIDTH  number of records transferred since reset.
REQ-013 parseErr  output  1  sticky malformed-input flag; present only with ROT_PARSE_ERR_EN.

Function
REQ-014 FSM states PARSE_IDLE, PARSE_DIGITS, PARSE_EMIT, one state per cycle, advancing only on accepted bytes or record transfers.
REQ-015 inReady SHALL be 1 in PARSE_IDLE and PARSE_DIGITS, 0 in PARSE_EMIT; rotValid SHALL be 1 only in PARSE_EMIT.
REQ-016 PARSE_IDLE: accepted 'L'/'R' latches rotDir, clears accumulator and digit flag, goes to PARSE_DIGITS; '\n', '\r', ' ' stay in PARSE_IDLE with no effect.
REQ-017 PARSE_DIGITS: accepted '0'..'9' updates acc = acc*10 + digit and sets the digit flag; the multiply is built as (acc<<3)+(acc<<1) in WIDTH+4 bits.
REQ-018 Accumulator overflow SHALL saturate at 2^WIDTH-1 and hold there until the record completes.
REQ-019 PARSE_DIGITS: accepted '\n' with the digit flag set goes to PARSE_EMIT; with the digit flag clear, the record is dropped and the FSM returns to PARSE_IDLE.
REQ-020 PARSE_DIGITS: accepted '\r' is ignored.
REQ-021 rotValid SHALL assert the cycle after the terminating '\n' is accepted, giving a latency of one cycle.
REQ-022 rotDir/rotMag SHALL remain stable while rotValid=1 && rotReady=0.
REQ-023 PARSE_EMIT: on transfer, the FSM goes to PARSE_IDLE and recCount increments; recCount saturates at all-ones.
REQ-024 Other characters (not L/R in IDLE, not digit/'\n'/'\r' in DIGITS) behave per REQ-030/031.
REQ-025 inValid=0 SHALL cause no state change in any state.

Reset
REQ-026 Reset SHALL force PARSE_IDLE, inReady=1, rotValid=0, rotDir=0, rotMag=0, recCount=0, and parseErr=0.
REQ-027 Reset asserted mid-record or during PARSE_EMIT SHALL discard the partial or pending record without a transfer or a count.
REQ-028 Reset has priority over any simultaneous byte or record transfer in the same cycle.

Configuration
REQ-029 Macro ROT_PARSE_ERR_EN compiles the error-detection feature in or out.
REQ-030 With ROT_PARSE_ERR_EN defined, an unexpected character sets parseErr, which stays 1 until reset, discards the current record, and returns the FSM to PARSE_IDLE.
REQ-031 Without ROT_PARSE_ERR_EN, the parseErr port is absent and unexpected characters are consumed and ignored with no state change.

Structure
REQ-032 Shared package aoc_pkg SHALL hold parseState_t and ASCII constants (ASCII_L, ASCII_R, ASCII_0, ASCII_9, ASCII_LF, ASCII_CR, ASCII_SP).
REQ-033 Sub-module dec_accum (WIDTH) SHALL implement clear, digit-accumulate, and saturation, exposing acc and the digit flag.
REQ-034 rotMag SHALL drive the downstream modulo stage's operand input directly.

Verification
REQ-035 Stream "L68\n" with rotReady=1 -> rotValid pulses 1 cycle after '\n', rotDir=0, rotMag=68, recCount=1.
REQ-036 Stream "R5\nL30\n" with rotReady low for 4 cycles -> first record held stable (1,5) and inReady=0 until transfer; then (0,30); recCount=2.
REQ-037 Stream "R99999\n" with WIDTH=16 -> rotMag=65535 (saturated), rotDir=1.
REQ-038 Stream "\n \rL\nR7\n" -> "L\n" dropped; single record (1,7); recCount=1.
REQ-039 Stream "L1x2\nR3\n" -> with ROT_PARSE_ERR_EN: parseErr=1, only (1,3) emitted; without it: (0,12) then (1,3).
REQ-040 Reset asserted after accepting "R4" -> no record emitted, recCount=0; subsequent "L2\n" yields (0,2).
